// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with parity, framing and overrun reporting.
// Samples each bit mid-period using a clk-to-baud divisor.
module uart_rx_os #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               st;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           bitn;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bit;
  logic                 fe_acc;
  logic                 pend;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_pe;
  logic                 pend_fe;
  logic                 par_fail;
  logic                 mid_bit;
  logic                 half_bit;

  assign mid_bit  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_bit = (cnt == CW'(HALF - 1));

  assign par_fail = (PARITY == 1) ? ~(^{sh, par_bit}) :
                    (PARITY == 2) ?  (^{sh, par_bit}) :
                    1'b0;

  // Two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM: mid-bit sampling, shift LSB first, stage the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      par_bit   <= 1'b0;
      fe_acc    <= 1'b0;
      busy      <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
      pend_pe   <= 1'b0;
      pend_fe   <= 1'b0;
    end else begin
      pend <= 1'b0;
      unique case (st)
        IDLE: begin
          cnt    <= '0;
          bitn   <= '0;
          fe_acc <= 1'b0;
          if (!rx_s) begin
            st   <= START;
            busy <= 1'b1;
          end
        end
        START: begin
          if (half_bit) begin
            cnt <= '0;
            if (rx_s) begin
              st   <= IDLE;
              busy <= 1'b0;
            end else begin
              st <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (mid_bit) begin
            cnt <= '0;
            sh  <= {rx_s, sh[DATA_BITS-1:1]};
            if (bitn == 4'(DATA_BITS - 1)) begin
              bitn <= '0;
              st   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bitn <= bitn + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (mid_bit) begin
            cnt     <= '0;
            par_bit <= rx_s;
            st      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (mid_bit) begin
            cnt <= '0;
            if (bitn == 4'(STOP_BITS - 1)) begin
              pend      <= 1'b1;
              pend_data <= sh;
              pend_pe   <= par_fail;
              pend_fe   <= fe_acc | ~rx_s;
              st        <= rx_s ? IDLE : WAIT_HIGH;
              busy      <= ~rx_s;
            end else begin
              bitn   <= bitn + 1'b1;
              fe_acc <= fe_acc | ~rx_s;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Output register: commit staged word, or consume on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (pend) begin
      if (!data_valid || data_ack) begin
        data       <= pend_data;
        parity_err <= pend_pe;
        frame_err  <= pend_fe;
        data_valid <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_valid && data_ack) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
